ingress_rdreq_cpl: RTL and testbench



---
 rtl/ingress_rdreq_cpl_if.sv | 43 ++++
 rtl/ingress_rdreq_cpl.sv | 145 ++++++++++++++
 tb/tb_ingress_rdreq_cpl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ingress_rdreq_cpl_if.sv
// ingress_rdreq_cpl_if
//   Bundles every non-clock/reset signal of ingress_rdreq_cpl.
//   Parser side    : rd_req, rd_tdest, req_id, req_tag, req_tc, req_attr, req_lower_addr
//   Config         : cfg_completer_id
//   Register port  : reg_rd_en, reg_rd_dest (out of block); reg_rd_data, reg_rd_vld (into block)
//   CplD stream    : cpl_data, cpl_keep, cpl_last, cpl_valid (out); cpl_ready (in)
//   Error pulses   : ovf_err, tmo_err
//   Modport slave is the completer block; modport master is its environment.
interface ingress_rdreq_cpl_if;
    logic        rd_req;
    logic [9:0]  rd_tdest;
    logic [15:0] req_id;
    logic [7:0]  req_tag;
    logic [2:0]  req_tc;
    logic [1:0]  req_attr;
    logic [6:0]  req_lower_addr;
    logic [15:0] cfg_completer_id;
    logic        reg_rd_en;
    logic [9:0]  reg_rd_dest;
    logic [31:0] reg_rd_data;
    logic        reg_rd_vld;
    logic [63:0] cpl_data;
    logic [1:0]  cpl_keep;
    logic        cpl_last;
    logic        cpl_valid;
    logic        cpl_ready;
    logic        ovf_err;
    logic        tmo_err;

    modport master (
        output rd_req, rd_tdest, req_id, req_tag, req_tc, req_attr, req_lower_addr,
        output cfg_completer_id, reg_rd_data, reg_rd_vld, cpl_ready,
        input  reg_rd_en, reg_rd_dest, cpl_data, cpl_keep, cpl_last, cpl_valid,
        input  ovf_err, tmo_err
    );

    modport slave (
        input  rd_req, rd_tdest, req_id, req_tag, req_tc, req_attr, req_lower_addr,
        input  cfg_completer_id, reg_rd_data, reg_rd_vld, cpl_ready,
        output reg_rd_en, reg_rd_dest, cpl_data, cpl_keep, cpl_last, cpl_valid,
        output ovf_err, tmo_err
    );
endinterface

// File: rtl/ingress_rdreq_cpl.sv
// ingress_rdreq_cpl
//   Queues read requests from the ingress parser, reads one 32-bit register per request
//   and answers each with a 3DW-header CplD TLP (1 DW payload) sent as two 64-bit beats.
// Ports
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : ingress_rdreq_cpl_if.slave (parser fields, register read port, CplD stream,
//          ovf_err / tmo_err pulses)
module ingress_rdreq_cpl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned DATA_WIDTH = 64
) (
    input logic                clk,
    input logic                rst,
    ingress_rdreq_cpl_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_BEAT0 = 3'd3;
    localparam logic [2:0] ST_BEAT1 = 3'd4;

    logic [45:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0]    state_q, state_d;
    logic [45:0]   hold_q, hold_d;
    logic [31:0]   data_q, data_d;
    logic [15:0]   cid_q, cid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic        full, empty, push, pop, tmo, valid;
    logic [45:0] entry;
    logic [31:0] dw0, dw1, dw2, dw3;
    logic [DATA_WIDTH-1:0] beat;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push  = bus.rd_req && !full;
    assign entry = {bus.rd_tdest, bus.req_id, bus.req_tag, bus.req_tc, bus.req_attr,
                    bus.req_lower_addr};

    assign wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    assign rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
    assign ovf_d  = bus.rd_req && full;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        data_d  = data_q;
        cid_d   = cid_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    hold_d  = mem_q[rptr_q[AW-1:0]];
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completer ID is frozen as the completion starts so both beats agree.
                if (bus.reg_rd_vld) begin
                    data_d  = bus.reg_rd_data;
                    cid_d   = bus.cfg_completer_id;
                    state_d = ST_BEAT0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    data_d  = 32'h0;
                    cid_d   = bus.cfg_completer_id;
                    tmo     = 1'b1;
                    state_d = ST_BEAT0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BEAT0: if (bus.cpl_ready) state_d = ST_BEAT1;
            ST_BEAT1: if (bus.cpl_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            state_q <= ST_IDLE;
            hold_q  <= '0;
            data_q  <= '0;
            cid_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            cid_q   <= cid_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Held entry: [45:36] tdest, [35:20] id, [19:12] tag, [11:9] tc, [8:7] attr, [6:0] addr
    assign dw0 = {3'b010, 5'b01010, 1'b0, hold_q[11:9], 4'b0000, 1'b0, 1'b0, hold_q[8:7],
                  2'b00, 10'd1};
    assign dw1 = {cid_q, 3'b000, 1'b0, 12'd4};
    assign dw2 = {hold_q[35:20], hold_q[19:12], 1'b0, hold_q[6:0]};
    assign dw3 = data_q;

    always_comb begin
        beat = '0;
        case (state_q)
            ST_BEAT0: beat = {dw1, dw0};
            ST_BEAT1: beat = {dw3, dw2};
            default:  beat = '0;
        endcase
    end

    assign valid           = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
    assign bus.cpl_data    = beat;
    assign bus.cpl_valid   = valid;
    assign bus.cpl_keep    = {2{valid}};
    assign bus.cpl_last    = (state_q == ST_BEAT1);
    assign bus.reg_rd_en   = (state_q == ST_RD);
    assign bus.reg_rd_dest = (state_q == ST_RD) ? hold_q[45:36] : 10'd0;
    assign bus.ovf_err     = ovf_q;
    assign bus.tmo_err     = tmo;
endmodule

// File: tb/tb_ingress_rdreq_cpl.sv
module tb_ingress_rdreq_cpl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [63:0] B0_PLAIN = 64'h0200_0004_4A00_0001;  // tc=0 attr=0
    localparam logic [63:0] B0_TC5A2 = 64'h0200_0004_4A50_2001;  // tc=5 attr=2

    ingress_rdreq_cpl_if b ();

    ingress_rdreq_cpl #(
        .FIFO_DEPTH(4),
        .TIMEOUT   (64),
        .DATA_WIDTH(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string what, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    // One-cycle rd_req; returns at the start of the following cycle.
    task automatic send(input logic [9:0] dest, input logic [7:0] tag, input logic [6:0] la);
        b.rd_req         = 1'b1;
        b.rd_tdest       = dest;
        b.req_tag        = tag;
        b.req_lower_addr = la;
        cyc();
        b.rd_req = 1'b0;
    endtask

    // Waits (bounded) for reg_rd_en, checks its target, returns in the first WAIT cycle.
    task automatic wait_rd_en(input string tag, input logic [9:0] dest, output int n);
        n = 0;
        while (b.reg_rd_en !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        chk(tag, "rd_en", 64'(b.reg_rd_en), 64'd1);
        chk(tag, "rd_dest", 64'(b.reg_rd_dest), 64'(dest));
        cyc();
    endtask

    // Called in a WAIT cycle with cpl_ready=1; answers the read and checks both beats.
    task automatic complete(input string tag, input logic [7:0] rtag, input logic [6:0] la,
                            input logic [31:0] rdata, input logic [63:0] exp0);
        logic [63:0] exp1;
        exp1 = {rdata, 16'h0100, rtag, 1'b0, la};
        b.reg_rd_vld  = 1'b1;
        b.reg_rd_data = rdata;
        cyc();
        b.reg_rd_vld  = 1'b0;
        b.reg_rd_data = 32'h0;
        chk(tag, "beat0", b.cpl_data, exp0);
        chk(tag, "beat0_ctl", 64'({b.cpl_valid, b.cpl_keep, b.cpl_last}), 64'b1110);
        cyc();
        chk(tag, "beat1", b.cpl_data, exp1);
        chk(tag, "beat1_ctl", 64'({b.cpl_valid, b.cpl_keep, b.cpl_last}), 64'b1111);
        cyc();
        chk(tag, "idle_valid", 64'(b.cpl_valid), 64'd0);
    endtask

    initial begin
        int n;
        int cnt;
        b.rd_req           = 1'b0;
        b.rd_tdest         = '0;
        b.req_id           = 16'h0100;
        b.req_tag          = '0;
        b.req_tc           = '0;
        b.req_attr         = '0;
        b.req_lower_addr   = '0;
        b.cfg_completer_id = 16'h0200;
        b.reg_rd_data      = '0;
        b.reg_rd_vld       = 1'b0;
        b.cpl_ready        = 1'b1;

        // Reset state
        repeat (3) cyc();
        chk("reset", "ctl", 64'({b.reg_rd_en, b.cpl_valid, b.cpl_keep, b.cpl_last,
                                 b.ovf_err, b.tmo_err}), 64'd0);
        chk("reset", "rd_dest", 64'(b.reg_rd_dest), 64'd0);
        chk("reset", "cpl_data", b.cpl_data, 64'd0);
        rst = 1'b0;
        cyc();

        // Single read with exact latency
        send(10'h2A3, 8'h05, 7'h24);
        chk("single", "T1_rd_en", 64'(b.reg_rd_en), 64'd0);
        cyc();
        chk("single", "T2_rd_en", 64'(b.reg_rd_en), 64'd1);
        chk("single", "rd_dest", 64'(b.reg_rd_dest), 64'h2A3);
        cyc();
        chk("single", "T3_rd_en", 64'(b.reg_rd_en), 64'd0);
        complete("single", 8'h05, 7'h24, 32'h1234_5678, B0_PLAIN);

        // Burst of 5, first one popped early: no overflow, in order
        b.req_tc   = 3'd5;
        b.req_attr = 2'd2;
        for (int i = 0; i < 5; i++) send(10'(256 + i), 8'(16 + i), 7'(4 * i));
        chk("burst", "ovf", 64'(b.ovf_err), 64'd0);
        complete("burst0", 8'h10, 7'd0, 32'hA000_0000, B0_TC5A2);
        for (int i = 1; i < 5; i++) begin
            wait_rd_en("burst", 10'(256 + i), n);
            chk("burst", "rd_en_gap", 64'(n), 64'd1);
            complete("burst", 8'(16 + i), 7'(4 * i), 32'(32'hA000_0000 + i), B0_TC5A2);
        end
        b.req_tc   = 3'd0;
        b.req_attr = 2'd0;

        // Overflow: 6 requests while the first read is outstanding
        for (int i = 0; i < 5; i++) send(10'(512 + i), 8'(32 + i), 7'(i));
        chk("ovf", "T5_ovf", 64'(b.ovf_err), 64'd0);
        send(10'd517, 8'd37, 7'd5);
        chk("ovf", "T6_ovf", 64'(b.ovf_err), 64'd1);
        cyc();
        chk("ovf", "T7_ovf", 64'(b.ovf_err), 64'd0);
        complete("ovf0", 8'd32, 7'd0, 32'hB000_0000, B0_PLAIN);
        for (int i = 1; i < 5; i++) begin
            wait_rd_en("ovf", 10'(512 + i), n);
            complete("ovf", 8'(32 + i), 7'(i), 32'(32'hB000_0000 + i), B0_PLAIN);
        end
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (b.reg_rd_en === 1'b1 || b.cpl_valid === 1'b1) cnt++;
        end
        chk("ovf", "dropped_activity", 64'(cnt), 64'd0);

        // Backpressure in BEAT0 for 10 cycles with a second request queued
        send(10'h011, 8'h30, 7'h10);
        wait_rd_en("bp", 10'h011, n);
        b.cpl_ready   = 1'b0;
        b.reg_rd_vld  = 1'b1;
        b.reg_rd_data = 32'hCAFE_F00D;
        cyc();
        b.reg_rd_vld  = 1'b0;
        send(10'h012, 8'h31, 7'h11);
        for (int i = 0; i < 10; i++) begin
            chk("bp", "beat0_hold", b.cpl_data, B0_PLAIN);
            chk("bp", "ctl_hold", 64'({b.cpl_valid, b.cpl_keep, b.cpl_last}), 64'b1110);
            chk("bp", "no_rd_en", 64'(b.reg_rd_en), 64'd0);
            cyc();
        end
        b.cpl_ready = 1'b1;
        cyc();
        chk("bp", "beat1", b.cpl_data, 64'hCAFE_F00D_0100_3010);
        chk("bp", "beat1_ctl", 64'({b.cpl_valid, b.cpl_keep, b.cpl_last}), 64'b1111);
        cyc();
        wait_rd_en("bp2", 10'h012, n);
        chk("bp2", "rd_en_gap", 64'(n), 64'd1);
        complete("bp2", 8'h31, 7'h11, 32'h0BAD_BEEF, B0_PLAIN);

        // Timeout: no reg_rd_vld; late vld is ignored
        send(10'h0F0, 8'h40, 7'h7F);
        cyc();
        chk("tmo", "rd_en", 64'(b.reg_rd_en), 64'd1);
        n = 0;
        while (b.tmo_err !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        chk("tmo", "delay", 64'(n), 64'd64);
        chk("tmo", "still_wait", 64'(b.cpl_valid), 64'd0);
        cyc();
        chk("tmo", "pulse_end", 64'(b.tmo_err), 64'd0);
        chk("tmo", "beat0", b.cpl_data, B0_PLAIN);
        b.reg_rd_vld  = 1'b1;
        b.reg_rd_data = 32'hDEAD_BEEF;
        cyc();
        chk("tmo", "beat1", b.cpl_data, 64'h0000_0000_0100_407F);
        b.reg_rd_vld  = 1'b0;
        b.reg_rd_data = 32'h0;
        cyc();
        chk("tmo", "idle_valid", 64'(b.cpl_valid), 64'd0);

        // Reset while in WAIT with two entries queued
        send(10'h050, 8'h50, 7'h00);
        send(10'h051, 8'h51, 7'h01);
        send(10'h052, 8'h52, 7'h02);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst", "valid", 64'({b.cpl_valid, b.reg_rd_en}), 64'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (b.reg_rd_en === 1'b1 || b.cpl_valid === 1'b1) cnt++;
        end
        chk("rst", "no_activity", 64'(cnt), 64'd0);
        send(10'h3FF, 8'h60, 7'h01);
        wait_rd_en("rst_new", 10'h3FF, n);
        complete("rst_new", 8'h60, 7'h01, 32'h55AA_55AA, B0_PLAIN);

        // Push and pop in the same cycle at full-1
        send(10'h070, 8'h70, 7'h00);
        send(10'h071, 8'h71, 7'h01);
        send(10'h072, 8'h72, 7'h02);
        send(10'h073, 8'h73, 7'h03);
        complete("pp_a", 8'h70, 7'h00, 32'hC000_0000, B0_PLAIN);
        send(10'h074, 8'h74, 7'h04);
        chk("pp", "rd_en_b", 64'(b.reg_rd_en), 64'd1);
        chk("pp", "dest_b", 64'(b.reg_rd_dest), 64'h071);
        send(10'h075, 8'h75, 7'h05);
        chk("pp", "ovf", 64'(b.ovf_err), 64'd0);
        complete("pp_b", 8'h71, 7'h01, 32'hC000_0001, B0_PLAIN);
        for (int i = 2; i < 6; i++) begin
            wait_rd_en("pp", 10'(112 + i), n);
            complete("pp", 8'(112 + i), 7'(i), 32'(32'hC000_0000 + i), B0_PLAIN);
        end
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (b.reg_rd_en === 1'b1) cnt++;
        end
        chk("pp", "drained", 64'(cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
